// File: rtl/counter_sequencer_if.sv
// Command channel into the counter sequencer: valid/ready handshake carrying
// the opcode and its argument.
interface counter_sequencer_if #(parameter int WIDTH = 16);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;

  modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/counter_sequencer.sv
// Command sequencer for one up/down counter: turns LOAD/UP/DOWN/BOUNCE commands
// into the counter's load strobe, count enable, direction and load data.
module counter_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  counter_sequencer_if.slave cmd,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_ld_n,
  output logic             cnt_en,
  output logic             cnt_updn,
  output logic [WIDTH-1:0] cnt_data,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             phase_dn,
  output logic [WIDTH-1:0] steps_left
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_DOWN   = 2'd2;
  localparam logic [1:0] OP_BOUNCE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       op;
  logic [WIDTH-1:0] n;
  logic             accept;
  logic             last_step;

  assign cmd.cmd_ready = (state == S_IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Abort masks the strobes in the very cycle it is seen, ahead of pause.
  assign cnt_en    = (state == S_RUN) && !pause && !abort;
  assign cnt_ld_n  = !((state == S_LOAD) && !abort);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign last_step = cnt_en && (steps_left == WIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      op         <= OP_LOAD;
      n          <= '0;
      cnt_updn   <= 1'b1;
      cnt_data   <= '0;
      aborted    <= 1'b0;
      phase_dn   <= 1'b0;
      steps_left <= '0;
    end else begin
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op       <= cmd.cmd_op;
            n        <= cmd.cmd_arg;
            phase_dn <= 1'b0;
            if (cmd.cmd_op == OP_LOAD) begin
              cnt_data   <= cmd.cmd_arg;
              steps_left <= '0;
              state      <= S_LOAD;
            end else if (cmd.cmd_arg == '0) begin
              // Zero-length run: no strobes, direction left untouched.
              steps_left <= '0;
              state      <= S_DONE;
            end else begin
              steps_left <= cmd.cmd_arg;
              cnt_updn   <= (cmd.cmd_op != OP_DOWN);
              state      <= S_RUN;
            end
          end
        end
        S_LOAD: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= S_IDLE;
          end else begin
            state <= S_DONE;
          end
        end
        S_RUN: begin
          if (abort) begin
            aborted    <= 1'b1;
            steps_left <= '0;
            phase_dn   <= 1'b0;
            state      <= S_IDLE;
          end else if (last_step) begin
            // BOUNCE turns around with no idle cycle between phases.
            if (op == OP_BOUNCE && !phase_dn) begin
              phase_dn   <= 1'b1;
              cnt_updn   <= 1'b0;
              steps_left <= n;
            end else begin
              phase_dn   <= 1'b0;
              steps_left <= '0;
              state      <= S_DONE;
            end
          end else if (cnt_en) begin
            steps_left <= steps_left - WIDTH'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A completed LOAD must be visible on the counter by the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst && state == S_DONE && op == OP_LOAD)
      assert (cnt_value == cnt_data);
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Command-driven controller for the 16-bit up/down counter datapath. It accepts LOAD / COUNT-UP / COUNT-DOWN / BOUNCE commands over a valid/ready handshake and drives the counter's active-low load strobe, count enable, direction and load data. Pause and abort controls let it be shared safely with timing logic above it. It sits directly in front of one counter instance and is the only driver of that counter's control pins.

Parameters:
WIDTH, 16, counter data width and step-count width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 BOUNCE
cmd_arg  input  WIDTH  load value (LOAD) or step count n (UP/DOWN/BOUNCE)
pause  input  1  suppress counting while high
abort  input  1  terminate current command
cnt_value  input  WIDTH  counter data_out, for monitoring only
cnt_ld_n  output  1  counter load strobe, active-low
cnt_en  output  1  counter count enable
cnt_updn  output  1  counter direction, 1 = up
cnt_data  output  WIDTH  counter load data
busy  output  1  command in progress (LOAD, RUN or DONE state)
done  output  1  one-cycle completion pulse
aborted  output  1  one-cycle abort pulse
phase_dn  output  1  BOUNCE second (down) phase active
steps_left  output  WIDTH  steps remaining in current phase

Behaviour:
- Reset: state IDLE. cnt_ld_n=1, cnt_en=0, cnt_updn=1, cnt_data=0, busy=0, done=0, aborted=0, phase_dn=0, steps_left=0. cmd_ready=1.
- States: IDLE, LOAD, RUN, DONE. cmd_ready = (state==IDLE), combinational.
- Accept: cmd_valid && cmd_ready at edge T. The command and argument are latched, and the first control cycle is T+1.
- LOAD: state LOAD for exactly one cycle (T+1) with cnt_ld_n=0 and cnt_data=arg. Then DONE at T+2, when cnt_value==arg.
- UP/DOWN with n>0: state RUN. cnt_updn=1 (UP) or 0 (DOWN), held for the whole command.
  - cnt_en = (state==RUN) && !pause && !abort, combinational.
  - steps_left loads n on accept and decrements on each cycle with cnt_en=1.
  - When the last step issues, the next state is DONE.
  - Without pause, cnt_en is high for cycles T+1..T+n and done is high at T+n+1.
- BOUNCE with n>0: RUN with phase_dn=0 and cnt_updn=1 for n enabled steps. Then phase_dn=1, cnt_updn=0, steps_left reloads n, and n down steps follow with no gap cycle. Then DONE. Net counter change is zero.
- n=0 for UP/DOWN/BOUNCE: go directly to DONE at T+1. No control strobes are issued.
- DONE: lasts exactly one cycle with done=1 and busy=1, then IDLE (cmd_ready=1 at the next cycle). In the DONE cycle, cnt_value equals the command's final value.
- Counter wrap-around (0xFFFF+1 -> 0, 0-1 -> 0xFFFF) is the counter's behaviour. The sequencer neither detects nor blocks it.
- Pause:
  - Affects RUN only; ignored in LOAD, DONE and IDLE.
  - While paused, cnt_en=0 and steps_left holds.
  - Pause does not extend a phase switch: the switch happens only after a counted step.
- Abort:
  - Sampled in LOAD or RUN. In that cycle cnt_en=0 and cnt_ld_n=1, combinationally.
  - Next cycle: state IDLE, aborted=1 for one cycle, done stays 0, steps_left=0, phase_dn=0.
  - Ignored in IDLE and DONE.
  - Abort has priority over pause.
- cnt_data changes only on LOAD accept and holds otherwise.
- When not in RUN, cnt_updn keeps its last value.
- Reset mid-command: immediate return to reset values, with no done or aborted pulse.
- cmd_valid while not ready: no effect. The command is neither latched nor dropped; the requester holds it.

Test Plan:
- Reset, then LOAD 0x1234 -> cnt_ld_n low for exactly 1 cycle, done 1 cycle later, cnt_value=0x1234 at done, cmd_ready returns next cycle.
- LOAD 0xFFFE, UP 3 -> cnt_en high 3 consecutive cycles, cnt_value 0xFFFF, 0x0000, 0x0001, done with cnt_value=0x0001.
- LOAD 0x0010, BOUNCE 4 with pause high for 2 cycles mid-up-phase -> 8 enabled cycles total, steps_left holds during pause, phase_dn rises after 4th up step, done with cnt_value=0x0010.
- DOWN 0 -> done at T+1, cnt_en never asserted; a back-to-back UP 1 is accepted at T+2.
- LOAD 0x0100, DOWN 10 with abort after 3rd step -> cnt_en low in abort cycle, aborted 1 cycle, no done, cnt_value=0x00FD.
- Reset asserted mid-RUN of UP 100 -> all outputs at reset values asynchronously, cmd_ready=1 after release, no done or aborted pulse.
